// File: rtl/spi_master.sv
// spi_master: register-access SPI initiator issuing 16-bit mode-0 frames {rw,000,addr,data}.
// Define SPIM_WR_VERIFY_EN to follow every write with an automatic read-back and compare.
module spi_master #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_done,
  output logic [7:0] rsp_rdata,
  output logic       verify_err,
  output logic       busy,
  output logic       ss,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic [2:0] dbg_state
);

  // Handshake: a command transfers on a clk edge where cmd_valid & cmd_ready;
  // cmd_ready is high only in IDLE, and cmd_valid seen elsewhere is dropped.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(IDLE_GAP - 1);

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [3:0]      bit_q, bit_n;
  logic            ss_q, ss_n;
  logic            sck_q, sck_n;
  logic            mosi_q, mosi_n;
  logic [14:0]     tx_q, tx_n;
  logic [7:0]      rx_q, rx_n;
  logic [7:0]      rdata_q, rdata_n;
  logic            done_q, done_n;
  logic            miso_s1, miso_s2;
  logic [15:0]     cmd_frame;
`ifdef SPIM_WR_VERIFY_EN
  logic            rw_q, rw_n;
  logic [3:0]      addr_q, addr_n;
  logic [7:0]      wdata_q, wdata_n;
  logic            vpass_q, vpass_n;
  logic            verr_q, verr_n;
`endif

  assign cmd_frame = {cmd_rw, 3'b000, cmd_addr, (cmd_rw ? 8'h00 : cmd_wdata)};

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    ss_n    = ss_q;
    sck_n   = sck_q;
    mosi_n  = mosi_q;
    tx_n    = tx_q;
    rx_n    = rx_q;
    rdata_n = rdata_q;
    done_n  = 1'b0;
`ifdef SPIM_WR_VERIFY_EN
    rw_n    = rw_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    vpass_n = vpass_q;
    verr_n  = verr_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_n = SETUP;
          cnt_n   = '0;
          ss_n    = 1'b0;
          mosi_n  = cmd_frame[15];
          tx_n    = cmd_frame[14:0];
`ifdef SPIM_WR_VERIFY_EN
          rw_n    = cmd_rw;
          addr_n  = cmd_addr;
          wdata_n = cmd_wdata;
          vpass_n = 1'b0;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_n = SHIFT;
          cnt_n   = '0;
          bit_n   = 4'd0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_n = cnt_q + 1'b1;
        end else begin
          cnt_n = '0;
          if (!sck_q) begin
            sck_n = 1'b1;
          end else begin
            // End of high phase: capture, then open the next low phase with new mosi.
            sck_n = 1'b0;
            rx_n  = {rx_q[6:0], miso_s2};
            if (bit_q == 4'd15) begin
              state_n = HOLD;
            end else begin
              bit_n  = bit_q + 4'd1;
              mosi_n = tx_q[14];
              tx_n   = {tx_q[13:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
          ss_n    = 1'b1;
          mosi_n  = 1'b0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q != GAP_LAST) begin
          cnt_n = cnt_q + 1'b1;
        end else begin
          cnt_n = '0;
`ifdef SPIM_WR_VERIFY_EN
          if (!rw_q && !vpass_q) begin
            // Chain the read-back frame straight out of the gap.
            state_n = SETUP;
            ss_n    = 1'b0;
            mosi_n  = 1'b1;
            tx_n    = {3'b000, addr_q, 8'h00};
            vpass_n = 1'b1;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
            rdata_n = rx_q;
            verr_n  = vpass_q && (rx_q != wdata_q);
          end
`else
          state_n = IDLE;
          done_n  = 1'b1;
          rdata_n = rx_q;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      ss_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= 8'h00;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
`ifdef SPIM_WR_VERIFY_EN
      rw_q    <= 1'b0;
      addr_q  <= 4'h0;
      wdata_q <= 8'h00;
      vpass_q <= 1'b0;
      verr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      ss_q    <= ss_n;
      sck_q   <= sck_n;
      mosi_q  <= mosi_n;
      tx_q    <= tx_n;
      rx_q    <= rx_n;
      rdata_q <= rdata_n;
      done_q  <= done_n;
      miso_s1 <= miso;
      miso_s2 <= miso_s1;
`ifdef SPIM_WR_VERIFY_EN
      rw_q    <= rw_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      vpass_q <= vpass_n;
      verr_q  <= verr_n;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_done  = done_q;
  assign rsp_rdata = rdata_q;
  assign ss        = ss_q;
  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign dbg_state = state_q;
`ifdef SPIM_WR_VERIFY_EN
  assign verify_err = verr_q;
`else
  assign verify_err = 1'b0;
`endif

endmodule
